// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive side of the multiplexed four-digit seven-segment driver. It watches
//   the scanned seg/select bus and rebuilds the four displayed BCD digits. A
//   frame is published only once every digit position has been captured.
//
// Ports
//   clk           system clock; seg/select are synchronous to it
//   rst           asynchronous, active-high reset
//   seg[6:0]      segment bus {g,f,e,d,c,b,a}, active-low
//   select[3:0]   digit enable, active-low one-hot; select[3] is the leftmost digit
//   d3..d0[3:0]   decoded digits of the last published frame (d3 = m2 ... d0 = s1)
//   digit_err[3:0] bit i set if digit i of the last frame had an illegal pattern
//   frame_valid   a frame has been published and no timeout has occurred since
//   frame_strobe  one-cycle pulse in the cycle the outputs update
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,        // 1..255
    parameter int TIMEOUT_CYCLES = 1048576   // >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic [3:0] select,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic [3:0] digit_err,
    output logic       frame_valid,
    output logic       frame_strobe
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [7:0]    SETTLE_MAX = 8'(SETTLE_CYCLES);
    localparam logic [7:0]    SETTLE_M1  = 8'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_M1      = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_M2      = TW'(TIMEOUT_CYCLES - 2);

    logic [3:0]      prevSelect;
    logic [7:0]      settleCnt;
    logic [7:0]      settleNow;
    logic [TW-1:0]   toCnt;
    logic [3:0]      mask;
    logic [3:0][3:0] shadowDig;
    logic [3:0]      shadowErr;

    logic [6:0]      segN;
    logic [3:0]      selN;
    logic            oneHot;
    logic            changed;
    logic            sampleFire;
    logic            complete;
    logic [3:0]      decVal;
    logic            decErr;
    logic [3:0][3:0] mergedDig;
    logic [3:0]      mergedErr;

    always_comb begin
        segN    = ~seg;
        selN    = ~select;
        oneHot  = (selN != 4'd0) && ((selN & (selN - 4'd1)) == 4'd0);
        changed = (select != prevSelect);

        // settleNow is the stable-cycle index of the current cycle: 0 on the
        // first cycle of a dwell. Saturating at SETTLE_CYCLES (one past the
        // firing value) guarantees exactly one sample per dwell.
        if (changed || !oneHot) begin
            settleNow = 8'd0;
        end else if (settleCnt >= SETTLE_MAX) begin
            settleNow = SETTLE_MAX;
        end else begin
            settleNow = settleCnt + 8'd1;
        end
        sampleFire = oneHot && (settleNow == SETTLE_M1);
        complete   = sampleFire && ((mask | selN) == 4'hF);
    end

    always_comb begin
        decErr = 1'b0;
        case (segN)
            7'h3F:   decVal = 4'd0;
            7'h06:   decVal = 4'd1;
            7'h5B:   decVal = 4'd2;
            7'h4F:   decVal = 4'd3;
            7'h66:   decVal = 4'd4;
            7'h6D:   decVal = 4'd5;
            7'h7D:   decVal = 4'd6;
            7'h07:   decVal = 4'd7;
            7'h7F:   decVal = 4'd8;
            7'h6F:   decVal = 4'd9;
            7'h00:   decVal = 4'hF;
            default: begin
                decVal = 4'hE;
                decErr = 1'b1;
            end
        endcase
    end

    // Shadow contents with the current sample folded in, so a completing
    // sample publishes its own digit without an extra cycle.
    always_comb begin
        mergedDig = shadowDig;
        mergedErr = shadowErr;
        for (int i = 0; i < 4; i++) begin
            if (sampleFire && selN[i]) begin
                mergedDig[i] = decVal;
                mergedErr[i] = decErr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevSelect   <= 4'd0;
            settleCnt    <= 8'd0;
            toCnt        <= '0;
            mask         <= 4'd0;
            shadowDig    <= '0;
            shadowErr    <= 4'd0;
            d3           <= 4'hF;
            d2           <= 4'hF;
            d1           <= 4'hF;
            d0           <= 4'hF;
            digit_err    <= 4'd0;
            frame_valid  <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            prevSelect   <= select;
            settleCnt    <= settleNow;
            frame_strobe <= complete;
            if (sampleFire) begin
                shadowDig <= mergedDig;
                shadowErr <= mergedErr;
                toCnt     <= '0;
                mask      <= complete ? 4'd0 : (mask | selN);
                if (complete) begin
                    d3          <= mergedDig[3];
                    d2          <= mergedDig[2];
                    d1          <= mergedDig[1];
                    d0          <= mergedDig[0];
                    digit_err   <= mergedErr;
                    frame_valid <= 1'b1;
                end
            end else if (toCnt != TO_M1) begin
                toCnt <= toCnt + 1'b1;
                // The step that lands on TIMEOUT_CYCLES-1 withdraws the frame.
                if (toCnt == TO_M2) begin
                    frame_valid <= 1'b0;
                    mask        <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

    localparam logic [6:0] P0 = 7'h3F, P1 = 7'h06, P2 = 7'h5B, P3 = 7'h4F, P4 = 7'h66;
    localparam logic [6:0] P5 = 7'h6D, P6 = 7'h7D, P7 = 7'h07, P8 = 7'h7F, P9 = 7'h6F;
    localparam logic [6:0] PBLANK = 7'h00, PBAD = 7'h49;
    localparam logic [3:0] M2 = 4'b0111, M1 = 4'b1011, S2 = 4'b1101, S1 = 4'b1110;
    localparam logic [3:0] IDLE = 4'b1111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic [3:0] select;
    logic [3:0] d3, d2, d1, d0, digit_err;
    logic       frame_valid, frame_strobe;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int strobeCnt = 0;
    int strobeCyc = -1;
    int fallCyc = -1;
    int c0;
    int sc;
    logic prevValid = 1'b0;

    seg_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .seg(seg), .select(select),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0), .digit_err(digit_err),
        .frame_valid(frame_valid), .frame_strobe(frame_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_strobe) begin
            strobeCnt++;
            strobeCyc = cyc;
        end
        if (prevValid && !frame_valid) fallCyc = cyc;
        prevValid = frame_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic dwell(input logic [3:0] sel, input logic [6:0] pat, input int n);
        select = sel;
        seg    = ~pat;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] digits();
        return 32'({d3, d2, d1, d0});
    endfunction

    initial begin
        rst    = 1'b1;
        select = IDLE;
        seg    = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits", digits(), 32'hFFFF);
        chk("rst_err", 32'(digit_err), 32'h0);
        chk("rst_valid", 32'(frame_valid), 32'h0);
        chk("rst_strobe", 32'(frame_strobe), 32'h0);
        rst = 1'b0;
        dwell(IDLE, PBLANK, 2);

        // basic scan 1,5,0,9, then stop and let it time out
        dwell(M2, P1, 8);
        dwell(M1, P5, 8);
        dwell(S2, P0, 8);
        c0 = cyc;
        dwell(S1, P9, 8);
        chk("scan_strobes", 32'(strobeCnt), 32'd1);
        chk("scan_strobe_cyc", 32'(strobeCyc), 32'(c0 + 4));
        chk("scan_digits", digits(), 32'h1509);
        chk("scan_err", 32'(digit_err), 32'h0);
        chk("scan_valid", 32'(frame_valid), 32'h1);
        dwell(IDLE, PBLANK, 20);
        chk("to_fall_cyc", 32'(fallCyc), 32'(c0 + 19));
        chk("to_valid", 32'(frame_valid), 32'h0);
        chk("to_digits_hold", digits(), 32'h1509);

        // short dwell on s2 leaves the frame incomplete
        sc = strobeCnt;
        dwell(M2, P2, 8);
        dwell(M1, P7, 8);
        dwell(S2, P4, 3);
        dwell(S1, P8, 8);
        chk("short_no_strobe", 32'(strobeCnt), 32'(sc));
        chk("short_digits_hold", digits(), 32'h1509);
        dwell(M2, P2, 8);
        dwell(M1, P7, 8);
        c0 = cyc;
        dwell(S2, P4, 8);
        chk("short_recover_strobes", 32'(strobeCnt), 32'(sc + 1));
        chk("short_recover_cyc", 32'(strobeCyc), 32'(c0 + 4));
        chk("short_recover_digits", digits(), 32'h2748);
        dwell(S1, P8, 8);
        dwell(IDLE, PBLANK, 20);

        // blank and illegal patterns
        dwell(M2, PBLANK, 8);
        dwell(M1, P3, 8);
        dwell(S2, P7, 8);
        dwell(S1, PBAD, 8);
        chk("err_digits", digits(), 32'hF37E);
        chk("err_bits", 32'(digit_err), 32'b0001);
        chk("err_valid", 32'(frame_valid), 32'h1);

        // multi-select glitch before the last digit
        sc = strobeCnt;
        dwell(M2, P6, 4);
        dwell(M1, P8, 4);
        dwell(S2, P2, 4);
        dwell(4'b0011, P8, 10);
        c0 = cyc;
        dwell(S1, P4, 8);
        chk("glitch_strobes", 32'(strobeCnt), 32'(sc + 1));
        chk("glitch_strobe_cyc", 32'(strobeCyc), 32'(c0 + 4));
        chk("glitch_digits", digits(), 32'h6824);
        chk("glitch_err", 32'(digit_err), 32'h0);

        // reset mid-frame discards partial captures
        dwell(M2, P9, 8);
        dwell(M1, P1, 8);
        rst = 1'b1;
        #1;
        chk("midrst_digits", digits(), 32'hFFFF);
        chk("midrst_valid", 32'(frame_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sc = strobeCnt;
        dwell(S2, P5, 8);
        dwell(S1, P0, 8);
        chk("midrst_no_strobe", 32'(strobeCnt), 32'(sc));
        chk("midrst_digits_blank", digits(), 32'hFFFF);
        dwell(M2, P9, 8);
        c0 = cyc;
        dwell(M1, P1, 8);
        chk("midrst_strobes", 32'(strobeCnt), 32'(sc + 1));
        chk("midrst_strobe_cyc", 32'(strobeCyc), 32'(c0 + 4));
        chk("midrst_final_digits", digits(), 32'h9150);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
